// File: rtl/svm_feature_packer.sv
// Packs F_WIDTH signed features into one vector over a ping-pong buffer pair, tags valence/arousal.
// Optional saturation of incoming features is enabled by defining SVM_FEAT_SAT_EN.
module svm_feature_packer #(
  parameter int NBITS       = 16,
  parameter int IN_BITS     = 24,
  parameter int F_WIDTH     = 32,
  parameter int LOG_F_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_BITS-1:0]       feat_in,
  input  logic                     feat_valid,
  input  logic                     feat_last,
  output logic                     feat_ready,
  output logic [NBITS*F_WIDTH-1:0] in_features,
  output logic                     fin_valid,
  input  logic                     fin_ready,
  output logic                     fin_modality,
  output logic                     len_err
);

  localparam logic [LOG_F_WIDTH-1:0] LAST_IDX = LOG_F_WIDTH'(F_WIDTH - 1);

  logic [NBITS-1:0]       r_data [2][F_WIDTH];
  logic [1:0]             r_full;
  logic [1:0]             r_tag;
  logic                   r_wr_buf;
  logic                   r_rd_buf;
  logic                   r_wr_mod;
  logic                   r_len_err;
  logic [LOG_F_WIDTH-1:0] r_wr_idx;

  logic                   w_accept;
  logic                   w_drain;
  logic                   w_at_last;
  logic [NBITS-1:0]       w_feat;

`ifdef SVM_FEAT_SAT_EN
  localparam logic signed [IN_BITS-1:0] SAT_MAX = {{(IN_BITS-NBITS+1){1'b0}}, {(NBITS-1){1'b1}}};
  localparam logic signed [IN_BITS-1:0] SAT_MIN = {{(IN_BITS-NBITS+1){1'b1}}, {(NBITS-1){1'b0}}};

  always_comb begin
    w_feat = feat_in[NBITS-1:0];
    if ($signed(feat_in) > SAT_MAX) begin
      w_feat = SAT_MAX[NBITS-1:0];
    end else if ($signed(feat_in) < SAT_MIN) begin
      w_feat = SAT_MIN[NBITS-1:0];
    end
  end
`else
  logic w_unused_hi;
  assign w_unused_hi = ^feat_in[IN_BITS-1:NBITS];
  assign w_feat      = feat_in[NBITS-1:0];
`endif

  // Ready depends only on registered occupancy, never on feat_valid.
  assign feat_ready   = ~r_full[r_wr_buf];
  assign w_accept     = feat_valid & feat_ready;
  assign w_drain      = r_full[r_rd_buf] & fin_ready;
  assign w_at_last    = (r_wr_idx == LAST_IDX);

  assign fin_valid    = r_full[r_rd_buf];
  assign fin_modality = r_tag[r_rd_buf];
  assign len_err      = r_len_err;

  generate
    for (genvar gi = 0; gi < F_WIDTH; gi++) begin : g_out
      assign in_features[gi*NBITS +: NBITS] = r_data[r_rd_buf][gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int j = 0; j < F_WIDTH; j++) begin
          r_data[b][j] <= '0;
        end
      end
    end else if (w_accept) begin
      r_data[r_wr_buf][r_wr_idx] <= w_feat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full    <= 2'b00;
      r_tag     <= 2'b00;
      r_wr_buf  <= 1'b0;
      r_rd_buf  <= 1'b0;
      r_wr_mod  <= 1'b0;
      r_len_err <= 1'b0;
      r_wr_idx  <= '0;
    end else begin
      // Drain and completion touch different buffers, so both may fire in one cycle.
      if (w_drain) begin
        r_full[r_rd_buf] <= 1'b0;
        r_rd_buf         <= ~r_rd_buf;
      end
      if (w_accept) begin
        if (w_at_last) begin
          r_full[r_wr_buf] <= 1'b1;
          r_tag[r_wr_buf]  <= r_wr_mod;
          r_wr_mod         <= ~r_wr_mod;
          r_wr_buf         <= ~r_wr_buf;
          r_wr_idx         <= '0;
          if (!feat_last) begin
            r_len_err <= 1'b1;
          end
        end else if (feat_last) begin
          // Short vector: drop it without consuming a modality slot.
          r_wr_idx  <= '0;
          r_len_err <= 1'b1;
        end else begin
          r_wr_idx <= r_wr_idx + LOG_F_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_svm_feature_packer.sv
// Self-checking bench for svm_feature_packer: scoreboard on the output handshake plus directed corner cases.
module tb_svm_feature_packer;

  localparam int NB  = 16;
  localparam int IB  = 24;
  localparam int FW  = 32;
  localparam int LFW = 5;
  localparam int VW  = NB * FW;

  logic          clk;
  logic          rst;
  logic [IB-1:0] feat_in;
  logic          feat_valid;
  logic          feat_last;
  logic          feat_ready;
  logic [VW-1:0] in_features;
  logic          fin_valid;
  logic          fin_ready;
  logic          fin_modality;
  logic          len_err;

  svm_feature_packer #(
    .NBITS(NB), .IN_BITS(IB), .F_WIDTH(FW), .LOG_F_WIDTH(LFW)
  ) dut (
    .clk(clk), .rst(rst), .feat_in(feat_in), .feat_valid(feat_valid),
    .feat_last(feat_last), .feat_ready(feat_ready), .in_features(in_features),
    .fin_valid(fin_valid), .fin_ready(fin_ready), .fin_modality(fin_modality),
    .len_err(len_err)
  );

  typedef struct {
    logic [VW-1:0] data;
    logic          mod;
  } exp_t;

  typedef struct {
    logic [IB-1:0] din;
    logic [NB-1:0] exp_trunc;
    logic [NB-1:0] exp_sat;
  } conv_vec_t;

  exp_t      sbq[$];
  conv_vec_t tbl[10];
  int        total = 0;
  int        bad = 0;
  int        n_out = 0;
  logic      model_mod = 1'b0;
  int        rdy_mode = 0;
  bit        gap_en = 1'b0;
  logic [IB-1:0] vec_buf[FW];
  logic          hold_prev = 1'b0;
  logic [VW-1:0] data_prev;
  logic          mod_prev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] conv(input logic [IB-1:0] x);
`ifdef SVM_FEAT_SAT_EN
    int s;
    s = $signed(x);
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
`endif
    return x[NB-1:0];
  endfunction

  // Sink-side ready: 0 = held low, 1 = held high, 2 = random per cycle.
  initial begin
    fin_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       fin_ready = 1'b0;
        1:       fin_ready = 1'b1;
        default: fin_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: scoreboard pop on handshake, and stability while stalled.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          check("hold_data", in_features, data_prev);
          check("hold_mod", fin_modality, mod_prev);
        end
        if (fin_valid && fin_ready) begin
          n_out++;
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_vector: got mod=%0d expected no vector", fin_modality);
          end else begin
            e = sbq.pop_front();
            $display("vector %0d out mod=%0d slot0=%h", n_out, fin_modality, in_features[NB-1:0]);
            check("vec_data", in_features, e.data);
            check("vec_mod", fin_modality, e.mod);
          end
        end
        hold_prev = fin_valid && !fin_ready;
        data_prev = in_features;
        mod_prev  = fin_modality;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_feat(input logic [IB-1:0] v, input logic l);
    int   cnt;
    logic rdy;
    feat_in    = v;
    feat_last  = l;
    feat_valid = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      rdy = feat_ready;
      @(posedge clk);
      #1;
      cnt++;
    end while (!rdy && cnt < 5000);
    feat_valid = 1'b0;
    feat_last  = 1'b0;
    if (!rdy) begin
      total++;
      bad++;
      $display("FAIL feat_ready_timeout: got ready=0 expected ready=1");
    end
  endtask

  // Send vec_buf[0..n-1]; feat_last on index last_at (-1 for none).
  task automatic send_buf(input int n, input int last_at);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      if (gap_en && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      if (n == FW && j == FW - 1) begin
        for (int k = 0; k < FW; k++) e.data[k*NB +: NB] = conv(vec_buf[k]);
        e.mod     = model_mod;
        model_mod = ~model_mod;
        sbq.push_back(e);
      end
      send_feat(vec_buf[j], 1'(j == last_at));
    end
  endtask

  task automatic fill_ramp(input int base);
    for (int j = 0; j < FW; j++) vec_buf[j] = IB'(base + j);
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    do begin
      @(posedge clk);
      c++;
    end while (sbq.size() != 0 && c < 5000);
    #1;
    check("drain_empty", sbq.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_fin_valid", fin_valid, 0);
    check("rst_fin_mod", fin_modality, 0);
    check("rst_len_err", len_err, 0);
    check("rst_in_features", in_features, 0);
    sbq.delete();
    model_mod = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst_feat_ready", feat_ready, 1);
  endtask

  initial begin
    rst        = 1'b0;
    feat_in    = '0;
    feat_valid = 1'b0;
    feat_last  = 1'b0;

    tbl[0] = '{24'h010000, 16'h0000, 16'h7FFF};
    tbl[1] = '{24'hFEEE90, 16'hEE90, 16'h8000};
    tbl[2] = '{24'h007FFF, 16'h7FFF, 16'h7FFF};
    tbl[3] = '{24'hFF8000, 16'h8000, 16'h8000};
    tbl[4] = '{24'h008000, 16'h8000, 16'h7FFF};
    tbl[5] = '{24'hFF7FFF, 16'h7FFF, 16'h8000};
    tbl[6] = '{24'h000005, 16'h0005, 16'h0005};
    tbl[7] = '{24'hFFFFFF, 16'hFFFF, 16'hFFFF};
    tbl[8] = '{24'h123456, 16'h3456, 16'h7FFF};
    tbl[9] = '{24'h800000, 16'h0000, 16'h8000};

    do_reset();

    // Single vector, latency and one-cycle valid pulse.
    rdy_mode = 1;
    fill_ramp(1);
    send_buf(FW, FW - 1);
    check("lat_fin_valid", fin_valid, 1);
    check("lat_fin_mod", fin_modality, 0);
    @(posedge clk);
    #1;
    check("pulse_fin_valid", fin_valid, 0);
    check("pulse_sb_empty", sbq.size(), 0);

    // Two vectors with sink stalled: both buffers fill, then drain in order.
    rdy_mode = 0;
    fill_ramp(1);
    send_buf(FW, FW - 1);
    fill_ramp(101);
    send_buf(FW, FW - 1);
    check("full_feat_ready", feat_ready, 0);
    check("full_fin_valid", fin_valid, 1);
    check("full_fin_mod", fin_modality, 1);
    rdy_mode = 1;
    @(negedge clk);
    check("pre_drain_ready", feat_ready, 0);
    @(posedge clk);
    #3;
    check("post_drain_ready", feat_ready, 1);
    wait_drain();
    check("b2b_feat_ready", feat_ready, 1);

    // Early last then a good vector; sticky length error, one output at valence.
    do_reset();
    rdy_mode = 1;
    fill_ramp(500);
    send_buf(10, 9);
    check("early_len_err", len_err, 1);
    check("early_no_valid", fin_valid, 0);
    fill_ramp(1);
    send_buf(FW, FW - 1);
    wait_drain();
    check("early_len_sticky", len_err, 1);

    // Missing last at slot F_WIDTH-1 still completes the vector.
    do_reset();
    rdy_mode = 0;
    fill_ramp(300);
    send_buf(FW, -1);
    check("nolast_len_err", len_err, 1);
    check("nolast_fin_valid", fin_valid, 1);
    rdy_mode = 1;
    wait_drain();

    // Conversion table in the first slots.
    do_reset();
    rdy_mode = 0;
    fill_ramp(40);
    for (int i = 0; i < 10; i++) vec_buf[i] = tbl[i].din;
    send_buf(FW, FW - 1);
    check("conv_fin_valid", fin_valid, 1);
    for (int i = 0; i < 10; i++) begin
`ifdef SVM_FEAT_SAT_EN
      check($sformatf("conv_slot%0d", i), in_features[i*NB +: NB], tbl[i].exp_sat);
`else
      check($sformatf("conv_slot%0d", i), in_features[i*NB +: NB], tbl[i].exp_trunc);
`endif
    end
    rdy_mode = 1;
    wait_drain();

    // Reset mid-vector with an arousal vector pending and len_err set.
    do_reset();
    rdy_mode = 1;
    fill_ramp(900);
    send_buf(5, 4);
    fill_ramp(1);
    send_buf(FW, FW - 1);
    wait_drain();
    rdy_mode = 0;
    fill_ramp(101);
    send_buf(FW, FW - 1);
    fill_ramp(201);
    send_buf(17, -1);
    check("pre_rst_fin_mod", fin_modality, 1);
    check("pre_rst_len_err", len_err, 1);
    rst = 1'b0;
    #1;
    check("midrst_fin_valid", fin_valid, 0);
    check("midrst_fin_mod", fin_modality, 0);
    check("midrst_len_err", len_err, 0);
    check("midrst_in_features", in_features, 0);
    sbq.delete();
    model_mod = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rdy_mode = 1;
    fill_ramp(301);
    send_buf(FW, FW - 1);
    wait_drain();
    check("postrst_len_err", len_err, 0);

    // Random backpressure on both sides over 40 vectors.
    rdy_mode = 2;
    gap_en   = 1'b1;
    for (int v = 0; v < 40; v++) begin
      for (int j = 0; j < FW; j++) vec_buf[j] = IB'($urandom());
      send_buf(FW, FW - 1);
    end
    rdy_mode = 1;
    wait_drain();
    @(posedge clk);
    #1;
    check("final_fin_valid", fin_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
